// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with CPOL/CPHA, bit order, select mask and abort
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_m,
    input  logic [7:0]        spcon,
    input  logic [7:0]        spibr,
    input  logic [NUM_SS-1:0] spssn,
    input  logic              miso,
    output logic [DATA_W-1:0] data_r_m,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_SS-1:0] ssn,
    output logic              busy,
    output logic              done
);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t state, state_next;

    // Half-period counter is 9 bits so spibr=255 (H=256) counts without wrapping.
    logic [8:0]        h_cnt;
    logic [8:0]        h_max;
    logic [EDGE_W-1:0] edge_cnt;
    logic              cpol_l;
    logic              cpha_l;
    logic              lsbfe_l;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              spen;
    logic              accept;
    logic              half_end;
    logic              leading;
    logic              unused_spcon;

    assign spen         = spcon[0];
    assign unused_spcon = ^spcon[7:4];
    assign accept       = (state == IDLE) && start && spen;
    assign half_end     = (h_cnt == h_max);
    // Even edge counts are leading edges (away from cpol), odd ones trailing.
    assign leading      = ~edge_cnt[0];

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // Receive assembles in transmit order so the result aligns with data_m.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic lsb,
                                                   input logic b);
        return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: phase lengths come from the half-period and edge counters; spen low aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: begin
                if (!spen)         state_next = IDLE;
                else if (half_end) state_next = XFER;
            end
            XFER: begin
                if (!spen)                                 state_next = IDLE;
                else if (half_end && edge_cnt == LAST_EDGE) state_next = HOLD;
            end
            HOLD: begin
                if (!spen)         state_next = IDLE;
                else if (half_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Half-period counter restarts on every phase change and every half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
        end else if (state == IDLE || state_next != state || half_end) begin
            h_cnt <= '0;
        end else begin
            h_cnt <= h_cnt + 9'd1;
        end
    end

    // Datapath and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ssn      <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_r_m <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsbfe_l  <= 1'b0;
            h_max    <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sck  <= spcon[2];
                    mosi <= 1'b0;
                    ssn  <= '1;
                    busy <= 1'b0;
                    if (accept) begin
                        cpol_l   <= spcon[2];
                        cpha_l   <= spcon[1];
                        lsbfe_l  <= spcon[3];
                        h_max    <= {1'b0, spibr};
                        ssn      <= ~spssn;
                        busy     <= 1'b1;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        if (spcon[1]) begin
                            tx_sr <= data_m;
                        end else begin
                            // CPHA=0 presents the first bit before the first edge.
                            mosi  <= first_bit(data_m, spcon[3]);
                            tx_sr <= shift_out(data_m, spcon[3]);
                        end
                    end
                end
                SETUP, XFER, HOLD: begin
                    if (!spen) begin
                        ssn  <= '1;
                        sck  <= cpol_l;
                        mosi <= 1'b0;
                        busy <= 1'b0;
                    end else if (half_end) begin
                        if (state == XFER) begin
                            sck      <= ~sck;
                            edge_cnt <= edge_cnt + 1'b1;
                            if (leading == cpha_l) begin
                                mosi  <= first_bit(tx_sr, lsbfe_l);
                                tx_sr <= shift_out(tx_sr, lsbfe_l);
                            end else begin
                                rx_sr <= shift_in(rx_sr, lsbfe_l, miso);
                            end
                        end else if (state == HOLD) begin
                            done     <= 1'b1;
                            data_r_m <= rx_sr;
                            busy     <= 1'b0;
                            ssn      <= '1;
                        end
                    end
                end
                DONE: begin
                    mosi <= 1'b0;
                end
                default: begin
                    mosi <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised successor to the fixed 8-bit Mode-0 SPI master. It adds configurable word width and slave-select count, all four CPOL/CPHA modes, and LSB/MSB-first ordering. It also adds an explicit start/busy/done handshake and a mid-transfer abort. It sits between the register/control block (which drives data_m, spcon, spibr, spssn) and the SPI pins.

Parameters:
DATA_W, 8, transfer word width in bits (2..32)
NUM_SS, 8, number of active-low slave-select lines (1..16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a transfer; accepted only in IDLE with spcon[0]=1
data_m  input  DATA_W  word to transmit; latched on accept
spcon  input  8  [0] spen, [1] cpha, [2] cpol, [3] lsbfe (1 = LSB first), [7:4] reserved and ignored
spibr  input  8  baud select; SCK half-period H = spibr+1 clk cycles; latched on accept
spssn  input  NUM_SS  slave-select mask; 1 = select that slave; latched on accept
miso  input  1  serial data from slave
data_r_m  output  DATA_W  last completed received word
mosi  output  1  serial data to slave
sck  output  1  SPI clock
ssn  output  NUM_SS  active-low slave selects
busy  output  1  high from the cycle after accept until done
done  output  1  one-cycle pulse on transfer completion

Behaviour:
- All outputs are registered. Reset values: sck=0, mosi=0, ssn=all 1, busy=0, done=0, data_r_m=0.
- Async reset forces reset values immediately, including mid-transfer. The FSM returns to IDLE.
- FSM states and transitions:
  - IDLE -> SETUP on a start accept.
  - SETUP -> XFER after H cycles.
  - XFER -> HOLD after 2*DATA_W SCK edges (2*DATA_W*H cycles).
  - HOLD -> DONE after H cycles.
  - DONE -> IDLE after 1 cycle.
- IDLE outputs: sck tracks spcon[2] (registered), ssn=all 1, mosi=0.
- Accept (cycle t0): latch data_m, cpol, cpha, lsbfe, H, spssn. From t0+1: busy=1 and ssn=~spssn_latched.
- Bit order: the first bit is data[DATA_W-1], or data[0] when lsbfe=1.
- CPHA=0:
  - First bit is on mosi at SETUP entry.
  - Leading SCK edge samples miso; trailing edge shifts the next bit out.
- CPHA=1:
  - Leading edge shifts the bit out (first bit appears at the first leading edge); trailing edge samples miso.
- Edge polarity: leading edge = away from cpol, trailing edge = back to cpol. sck returns to cpol after the last edge and stays there through HOLD.
- Receive bits are assembled in the same order as transmit, so the received word is aligned identically to data_m.
- DONE cycle (t0+1+(2*DATA_W+2)*H):
  - done=1, data_r_m updated, busy=0, ssn=all 1.
  - mosi returns to 0 in IDLE.
- start while busy is ignored; no queuing.
- start with spen=0 is ignored.
- Changes to data_m, spibr, spssn or spcon[3:1] during a transfer have no effect.
- Abort: if spen drops to 0 in SETUP, XFER or HOLD, the next cycle is IDLE:
  - ssn=all 1, sck=cpol, mosi=0, busy=0.
  - No done pulse; data_r_m is unchanged.
- spssn=0: the transfer runs normally with no slave selected.
- spibr=255 gives H=256; the half-period counter must be 8 bits plus carry, with no wrap error.

Test Plan:
1. DATA_W=8, NUM_SS=4, Mode0, spibr=0, spssn=4'b0001, data_m=8'hA5, miso looped from mosi -> ssn=4'b1110 during the transfer, 8 rising sck edges, done at t0+19, data_r_m=8'hA5.
2. Mode3 (cpol=1, cpha=1), spibr=3, data_m=8'h3C, miso tied 1 -> sck idles high, each half-period is 4 cycles, mosi bits 0,0,1,1,1,1,0,0 on falling edges, done at t0+73, data_r_m=8'hFF.
3. Mode1, lsbfe=1, data_m=8'h01, loopback -> first mosi bit 1 then seven 0s, data_r_m=8'h01. Repeat with lsbfe=0 and data_m=8'h80 -> identical mosi waveform.
4. Start Mode0 spibr=1 transfer of 8'hF0; pulse start with data_m=8'h0F at the 3rd sck edge -> second request ignored, mosi carries 8'hF0, exactly one done.
5. Clear spen after 5 sck edges -> next cycle ssn=all 1, busy=0, sck=cpol, no done pulse, data_r_m retains its previous value 8'hA5.
6. Assert rst_n=0 mid-XFER (async, between clk edges) -> sck=0, mosi=0, ssn=all 1, busy=0, data_r_m=0 immediately. After release, a new transfer completes correctly.
